// File: rtl/frame_seq_pkg.sv
// Shared definitions for the serial frame-receive sequencer: state encoding and
// default sizing. Optional DETECT watchdog is enabled by defining FRAME_TIMEOUT_EN.
package frame_seq_pkg;

  localparam int unsigned LEN_W_DEF          = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_DETECT  = 3'd2,
    ST_LENGTH  = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/frame_len_counter.sv
// Loadable payload down counter; stops at zero and flags the last remaining bit.
module frame_len_counter
  import frame_seq_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ld,
  input  logic             en,
  input  logic [LEN_W-1:0] din,
  output logic             is_one,
  output logic             is_zero
);

  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= din;
    end else if (en && !is_zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one  = (cnt == LEN_W'(1));
  assign is_zero = (cnt == '0);

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame-receive sequencer: arm detector, capture MSB-first length, gate payload, pulse done.
// Define FRAME_TIMEOUT_EN to add the DETECT-state watchdog and its timeout pulse.
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int unsigned LEN_W          = LEN_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             w_det,
  output logic             ready,
  output logic             en_det,
  output logic             out_valid,
  output logic             serial_out,
  output logic             done,
  output logic [LEN_W-1:0] length,
  output logic             timeout
);

  localparam int unsigned BC_W = $clog2(LEN_W);

  if (LEN_W < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("frame_seq_ctrl: LEN_W must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_t           state;
  logic [LEN_W-2:0] sr;
  logic [BC_W-1:0]  bit_cnt;
  logic [LEN_W-1:0] len;
  logic             last_bit;
  logic             cnt_is_one;
  logic             cnt_is_zero;
  logic             wd_expire;

  assign len      = {sr, serial_in};
  assign last_bit = (state == ST_LENGTH) && (bit_cnt == BC_W'(LEN_W - 1));

  frame_len_counter #(
    .LEN_W (LEN_W)
  ) u_len_counter (
    .clock   (clock),
    .reset   (reset),
    .ld      (last_bit),
    .en      (state == ST_PAYLOAD),
    .din     (len),
    .is_one  (cnt_is_one),
    .is_zero (cnt_is_zero)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog;

  // wdog counts DETECT cycles already elapsed; it is zero on the first DETECT cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == ST_DETECT) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end

  assign wd_expire = (state == ST_DETECT) && !w_det &&
                     (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout   = wd_expire;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      length  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_INIT;
        end
        ST_INIT: begin
          bit_cnt <= '0;
          if (!start) state <= ST_DETECT;
        end
        ST_DETECT: begin
          if (w_det) begin
            state <= ST_LENGTH;
          end else if (wd_expire) begin
            state <= ST_IDLE;
          end
        end
        ST_LENGTH: begin
          sr      <= len[LEN_W-2:0];
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            length <= len;
            state  <= (len == '0) ? ST_DONE : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          // is_zero is only a guard; the counter is never zero on PAYLOAD entry
          if (cnt_is_one || cnt_is_zero) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready      = (state == ST_IDLE);
  assign en_det     = (state == ST_INIT) || (state == ST_DETECT);
  assign out_valid  = (state == ST_PAYLOAD);
  assign done       = (state == ST_DONE);
  assign serial_out = serial_in & out_valid;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Self-checking bench for frame_seq_ctrl: directed vector table, hand sequences and
// randomized frames against a phase-level model. Watchdog cases need FRAME_TIMEOUT_EN.
module tb_frame_seq_ctrl;

  localparam int unsigned LEN_W = 8;
  localparam int unsigned TOC   = 10;

  // expected output vector: {ready, en_det, out_valid, serial_out, done, timeout}
  localparam logic [5:0] E_RDY  = 6'b100000;
  localparam logic [5:0] E_DET  = 6'b010000;
  localparam logic [5:0] E_OV   = 6'b001000;
  localparam logic [5:0] E_OV1  = 6'b001100;
  localparam logic [5:0] E_DONE = 6'b000010;
  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_TO   = 6'b010001;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             serial_in;
  logic             w_det;
  logic             ready;
  logic             en_det;
  logic             out_valid;
  logic             serial_out;
  logic             done;
  logic [LEN_W-1:0] length;
  logic             timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [LEN_W-1:0] mlen;

  typedef struct {
    logic             rs;
    logic             s;
    logic             si;
    logic             wd;
    logic [5:0]       ev;
    logic [LEN_W-1:0] elen;
  } vec_t;

  vec_t tbl[$];

  frame_seq_ctrl #(
    .LEN_W          (LEN_W),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .serial_in  (serial_in),
    .w_det      (w_det),
    .ready      (ready),
    .en_det     (en_det),
    .out_valid  (out_valid),
    .serial_out (serial_out),
    .done       (done),
    .length     (length),
    .timeout    (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // drive one cycle's inputs, compare outputs at the falling edge, advance past posedge
  task automatic tick(input logic rs, input logic s, input logic si, input logic wd,
                      input logic [5:0] ev, input logic [LEN_W-1:0] elen, input string nm);
    logic [5:0] got;
    reset = rs; start = s; serial_in = si; w_det = wd;
    @(negedge clock);
    got = {ready, en_det, out_valid, serial_out, done, timeout};
    n_tests++;
    if (got !== ev || length !== elen) begin
      n_fail++;
      $display("FAIL %s cyc=%0d outputs got=%b len=%h, expected outputs=%b len=%h",
               nm, cyc, got, length, ev, elen);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic void add(input logic rs, input logic s, input logic si, input logic wd,
                              input logic [5:0] ev, input logic [LEN_W-1:0] elen);
    vec_t v;
    v.rs = rs; v.s = s; v.si = si; v.wd = wd; v.ev = ev; v.elen = elen;
    tbl.push_back(v);
  endfunction

  function automatic void add_len(input logic [LEN_W-1:0] v, input logic [LEN_W-1:0] prev);
    for (int b = LEN_W - 1; b >= 0; b--) add(1'b0, 1'b0, v[b], 1'b0, E_NONE, prev);
  endfunction

  // phase-level model of one complete frame: idle/start, INIT hold, DETECT wait,
  // length field, L payload bits, done; inputs that must be ignored are randomized
  task automatic frame(input int hold, input int dwait, input int L, input string nm);
    logic [LEN_W-1:0] lv;
    logic si;
    lv = LEN_W'(L);
    tick(1'b0, 1'b1, rb(), rb(), E_RDY, mlen, nm);
    for (int i = 0; i < hold; i++) tick(1'b0, 1'b1, rb(), rb(), E_DET, mlen, nm);
    tick(1'b0, 1'b0, rb(), rb(), E_DET, mlen, nm);
    for (int i = 0; i < dwait; i++) tick(1'b0, rb(), rb(), 1'b0, E_DET, mlen, nm);
    tick(1'b0, rb(), rb(), 1'b1, E_DET, mlen, nm);
    for (int b = LEN_W - 1; b >= 0; b--) tick(1'b0, rb(), lv[b], rb(), E_NONE, mlen, nm);
    mlen = lv;
    for (int p = 0; p < L; p++) begin
      si = rb();
      tick(1'b0, rb(), si, rb(), si ? E_OV1 : E_OV, mlen, nm);
    end
    tick(1'b0, rb(), rb(), rb(), E_DONE, mlen, nm);
    tick(1'b0, 1'b0, rb(), rb(), E_RDY, mlen, nm);
  endtask

  initial begin
    logic [LEN_W-1:0] v16;
    reset = 1'b1; start = 1'b0; serial_in = 1'b0; w_det = 1'b0;
    mlen = '0;
    @(posedge clock);
    #1;
    tick(1'b1, 1'b1, 1'b1, 1'b1, E_RDY, 8'h00, "reset_state");

    // length 3, payload 1,0,1; start held 2 cycles
    add(0, 1, 0, 0, E_RDY, 8'h00);
    add(0, 1, 0, 0, E_DET, 8'h00);
    add(0, 0, 0, 0, E_DET, 8'h00);
    add(0, 0, 0, 1, E_DET, 8'h00);
    add_len(8'h03, 8'h00);
    add(0, 0, 1, 0, E_OV1, 8'h03);
    add(0, 0, 0, 0, E_OV,  8'h03);
    add(0, 0, 1, 0, E_OV1, 8'h03);
    add(0, 1, 1, 0, E_DONE, 8'h03);
    add(0, 0, 0, 0, E_RDY, 8'h03);
    // zero length: done right after the length field; w_det-cycle serial_in discarded
    add(0, 1, 0, 0, E_RDY, 8'h03);
    add(0, 0, 0, 0, E_DET, 8'h03);
    add(0, 0, 1, 1, E_DET, 8'h03);
    add_len(8'h00, 8'h03);
    add(0, 0, 0, 0, E_DONE, 8'h00);
    add(0, 0, 0, 0, E_RDY, 8'h00);
    // start held 5 cycles with w_det pulses in INIT, then length 2
    add(0, 1, 0, 0, E_RDY, 8'h00);
    add(0, 1, 0, 0, E_DET, 8'h00);
    add(0, 1, 0, 1, E_DET, 8'h00);
    add(0, 1, 0, 0, E_DET, 8'h00);
    add(0, 1, 0, 1, E_DET, 8'h00);
    add(0, 0, 0, 0, E_DET, 8'h00);
    add(0, 0, 0, 1, E_DET, 8'h00);
    add_len(8'h02, 8'h00);
    add(0, 0, 1, 0, E_OV1, 8'h02);
    add(0, 0, 1, 0, E_OV1, 8'h02);
    add(0, 0, 0, 0, E_DONE, 8'h02);
    add(0, 0, 0, 0, E_RDY, 8'h02);

    foreach (tbl[i]) tick(tbl[i].rs, tbl[i].s, tbl[i].si, tbl[i].wd, tbl[i].ev, tbl[i].elen, "table");
    mlen = 8'h02;

    // maximum length: 255 consecutive payload cycles
    frame(0, 2, 255, "max_len");

    // reset in the 5th payload cycle of a 16-bit frame
    v16 = 8'h10;
    tick(1'b0, 1'b1, 1'b0, 1'b0, E_RDY, mlen, "rst_mid");
    tick(1'b0, 1'b0, 1'b0, 1'b0, E_DET, mlen, "rst_mid");
    tick(1'b0, 1'b0, 1'b0, 1'b1, E_DET, mlen, "rst_mid");
    for (int b = LEN_W - 1; b >= 0; b--) tick(1'b0, 1'b0, v16[b], 1'b0, E_NONE, mlen, "rst_mid");
    mlen = v16;
    for (int p = 0; p < 4; p++) tick(1'b0, 1'b0, 1'b1, 1'b0, E_OV1, mlen, "rst_mid");
    tick(1'b1, 1'b0, 1'b1, 1'b0, E_OV1, mlen, "rst_mid");
    mlen = '0;
    tick(1'b1, 1'b1, 1'b1, 1'b1, E_RDY, mlen, "rst_after");
    tick(1'b0, 1'b0, 1'b0, 1'b0, E_RDY, mlen, "rst_wins");

    for (int f = 0; f < 25; f++) begin
      int L;
      L = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), L, "random");
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        tick(1'b0, 1'b0, rb(), rb(), E_RDY, mlen, "random_gap");
    end

`ifdef FRAME_TIMEOUT_EN
    tick(1'b0, 1'b1, 1'b0, 1'b0, E_RDY, mlen, "timeout");
    tick(1'b0, 1'b0, 1'b0, 1'b0, E_DET, mlen, "timeout");
    for (int i = 1; i < TOC; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, E_DET, mlen, "timeout_wait");
    tick(1'b0, 1'b0, 1'b0, 1'b0, E_TO, mlen, "timeout_pulse");
    tick(1'b0, 1'b0, 1'b0, 1'b0, E_RDY, mlen, "timeout_idle");
    tick(1'b0, 1'b1, 1'b0, 1'b0, E_RDY, mlen, "timeout_race");
    tick(1'b0, 1'b0, 1'b0, 1'b0, E_DET, mlen, "timeout_race");
    for (int i = 1; i < TOC; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, E_DET, mlen, "timeout_race");
    tick(1'b0, 1'b0, 1'b0, 1'b1, E_DET, mlen, "timeout_race_hit");
    for (int b = 0; b < int'(LEN_W); b++) tick(1'b0, 1'b0, 1'b0, 1'b0, E_NONE, mlen, "timeout_race_len");
    mlen = '0;
    tick(1'b0, 1'b0, 1'b0, 1'b0, E_DONE, mlen, "timeout_race_done");
    tick(1'b0, 1'b0, 1'b0, 1'b0, E_RDY, mlen, "timeout_race_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
